// File: rtl/axi4_lite_req_arbiter_pkg.sv
// Shared definitions for the AXI4-Lite requester arbiter: bus widths, FSM states
// and the selected-request bundle.
package axi4_lite_Defs;

  localparam int Addr_Width = 32;
  localparam int Data_Width = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

  typedef struct packed {
    logic                  write;
    logic [Addr_Width-1:0] addr;
    logic [Data_Width-1:0] wdata;
  } arb_cmd_t;

endpackage

// File: rtl/axi4_lite_req_arbiter_rr.sv
// Combinational round-robin pick: first set request after ptr, with wrap-around.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] pos;

  // Scan from the farthest candidate back to ptr+1 so the nearest one overwrites.
  always_comb begin
    grant = '0;
    idx   = '0;
    pos   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_req_arbiter.sv
// Round-robin sequencer sharing one AXI4-Lite master command port among NUM_REQ requesters.
// Optional WAIT timeout with error completion: define AXI4_ARB_TIMEOUT_EN.
module axi4_lite_req_arbiter
  import axi4_lite_Defs::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ-1:0][Addr_Width-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][Data_Width-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [Data_Width-1:0]               rsp_rdata,
  output logic                                rsp_err,
  output logic                                rd_en,
  output logic                                wr_en,
  output logic [Addr_Width-1:0]               Read_Address,
  output logic [Addr_Width-1:0]               Write_Address,
  output logic [Data_Width-1:0]               Write_Data,
  input  logic                                rd_done,
  input  logic                                wr_done,
  input  logic [Data_Width-1:0]               rd_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("axi4_lite_req_arbiter: unsupported NUM_REQ/TIMEOUT_CYCLES");
  end

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gidx;
  logic             cmd_write;

  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  arb_cmd_t           sel;
  logic               done_hit;
  logic               to_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (win_oh),
    .idx   (win_idx)
  );

  assign win_any   = |win_oh;
  assign sel       = '{write: req_write[win_idx], addr: req_addr[win_idx], wdata: req_wdata[win_idx]};
  assign req_ready = (ARESETN && state == IDLE) ? win_oh : '0;
  // Only the done matching the issued direction can complete a transaction.
  assign done_hit  = cmd_write ? wr_done : rd_done;

`ifdef AXI4_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;

  assign to_hit = (state == WAIT) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)            to_cnt <= '0;
    else if (state == ISSUE) to_cnt <= '0;
    else if (state == WAIT)  to_cnt <= to_cnt + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      ptr           <= IDX_W'(NUM_REQ - 1);
      gidx          <= '0;
      cmd_write     <= 1'b0;
      rd_en         <= 1'b0;
      wr_en         <= 1'b0;
      Read_Address  <= '0;
      Write_Address <= '0;
      Write_Data    <= '0;
      rsp_valid     <= '0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      rd_en     <= 1'b0;
      wr_en     <= 1'b0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      unique case (state)
        IDLE: if (win_any) begin
          // Master-side outputs load at accept so the enable lands in ISSUE.
          gidx      <= win_idx;
          ptr       <= win_idx;
          cmd_write <= sel.write;
          rd_en     <= ~sel.write;
          wr_en     <= sel.write;
          if (sel.write) begin
            Write_Address <= sel.addr;
            Write_Data    <= sel.wdata;
          end else begin
            Read_Address  <= sel.addr;
          end
          state <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (done_hit) begin
            rsp_valid <= NUM_REQ'(1) << gidx;
            rsp_rdata <= cmd_write ? '0 : rd_data;
            state     <= RESP;
          end else if (to_hit) begin
            rsp_valid <= NUM_REQ'(1) << gidx;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Bench for axi4_lite_req_arbiter: timestamp-based reference model checked every cycle
// plus directed scenarios with literal expectations. Timeout cases need AXI4_ARB_TIMEOUT_EN.
module tb_axi4_lite_req_arbiter;
  import axi4_lite_Defs::*;

  localparam int N    = 4;
  localparam int TO   = 8;
  localparam int NONE = 32'h7fffffff;

  logic ACLK = 1'b0;
  logic ARESETN;
  logic [N-1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [N-1:0][Addr_Width-1:0] req_addr;
  logic [N-1:0][Data_Width-1:0] req_wdata;
  logic [Data_Width-1:0] rsp_rdata, Write_Data, rd_data;
  logic [Addr_Width-1:0] Read_Address, Write_Address;
  logic rsp_err, rd_en, wr_en, rd_done, wr_done;

  always #5 ACLK = ~ACLK;

  axi4_lite_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rd_en(rd_en), .wr_en(wr_en), .Read_Address(Read_Address), .Write_Address(Write_Address),
    .Write_Data(Write_Data), .rd_done(rd_done), .wr_done(wr_done), .rd_data(rd_data)
  );

  int n_total = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: a transaction is a timeline anchored on its accept cycle.
  int cyc = 0, m_ptr = N - 1, m_g = 0, m_acc = 0, m_rsp = NONE, p;
  bit m_busy = 0, m_wr = 0, m_err = 0, e_rd, e_wr;
  logic [31:0] m_addr, m_wdata, m_rd, e_raddr, e_waddr, e_wdata;
  logic [N-1:0] exp_rdy, exp_rsp;

  // Event logs of what the DUT actually did, for the directed literal checks.
  int grant_idx[256], grant_cyc[256], issue_cyc[256], rsp_idx[256], rsp_cyc[256];
  logic [31:0] rsp_dat[256];
  logic rsp_e[256];
  int n_grant = 0, n_issue = 0, n_wr_hi = 0, n_rsp = 0;

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      m_busy = 0; m_ptr = N - 1; m_rsp = NONE;
      e_raddr = 0; e_waddr = 0; e_wdata = 0;
      check("rst_req_ready", req_ready, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_read_addr", Read_Address, 0);
      check("rst_write_addr", Write_Address, 0);
      check("rst_write_data", Write_Data, 0);
    end else begin
      cyc++;
      e_rd = m_busy && (cyc == m_acc + 1) && !m_wr;
      e_wr = m_busy && (cyc == m_acc + 1) && m_wr;
      if (e_rd) e_raddr = m_addr;
      if (e_wr) begin e_waddr = m_addr; e_wdata = m_wdata; end
      check("rd_en", rd_en, e_rd);
      check("wr_en", wr_en, e_wr);
      check("en_exclusive", rd_en & wr_en, 0);
      check("read_addr", Read_Address, e_raddr);
      check("write_addr", Write_Address, e_waddr);
      check("write_data", Write_Data, e_wdata);

      exp_rsp = (m_busy && cyc == m_rsp) ? (N'(1) << m_g) : '0;
      check("rsp_valid", rsp_valid, exp_rsp);
      if (exp_rsp != 0) begin
        check("rsp_err", rsp_err, m_err);
        if (!m_wr || m_err) check("rsp_rdata", rsp_rdata, m_rd);
      end else begin
        check("rsp_err_quiet", rsp_err, 0);
      end

      exp_rdy = '0;
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          p = (m_ptr + k) % N;
          if (req_valid[p]) begin exp_rdy[p] = 1'b1; m_g = p; break; end
        end
      end
      check("req_ready", req_ready, exp_rdy);

      if (exp_rdy != 0) begin
        m_busy = 1; m_acc = cyc; m_rsp = NONE; m_ptr = m_g;
        m_wr = req_write[m_g]; m_addr = req_addr[m_g]; m_wdata = req_wdata[m_g];
      end else if (m_busy && m_rsp == NONE && cyc >= m_acc + 2) begin
        if (m_wr ? wr_done : rd_done) begin
          m_rsp = cyc + 1; m_err = 0; m_rd = m_wr ? 32'h0 : rd_data;
        end
`ifdef AXI4_ARB_TIMEOUT_EN
        else if (cyc - (m_acc + 2) == TO - 1) begin
          m_rsp = cyc + 1; m_err = 1; m_rd = 32'h0;
        end
`endif
      end else if (m_busy && cyc == m_rsp) begin
        m_busy = 0;
      end

      if (req_ready != 0) begin
        grant_idx[n_grant] = oh_idx(req_ready); grant_cyc[n_grant] = cyc; n_grant++;
      end
      if (rd_en | wr_en) begin issue_cyc[n_issue] = cyc; n_issue++; end
      if (wr_en) n_wr_hi++;
      if (rsp_valid != 0) begin
        rsp_idx[n_rsp] = oh_idx(rsp_valid); rsp_cyc[n_rsp] = cyc;
        rsp_dat[n_rsp] = rsp_rdata; rsp_e[n_rsp] = rsp_err; n_rsp++;
      end
    end
  end

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic wait_issue(output bit ok, output bit was_wr);
    ok = 0; was_wr = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rd_en | wr_en) begin ok = 1; was_wr = wr_en; break; end
    end
    check("issue_seen", ok, 1);
  endtask

  // Answer the next issue with its matching done dly cycles later.
  task automatic serve(input int dly, input logic [31:0] data, input bit keep);
    bit ok, w;
    wait_issue(ok, w);
    if (!keep && n_grant > 0) req_valid[grant_idx[n_grant-1]] = 1'b0;
    repeat (dly) tick();
    if (w) wr_done = 1'b1;
    else begin rd_done = 1'b1; rd_data = data; end
    tick();
    rd_done = 1'b0; wr_done = 1'b0;
  endtask

  initial begin
    int gb, ib, rb, wb;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    ARESETN = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    rd_done = 1'b0; wr_done = 1'b0; rd_data = '0;
    repeat (3) tick();

    // All four requesters held from reset; requesters 1 and 3 write.
    req_write = 4'b1010;
    for (int i = 0; i < N; i++) begin
      req_addr[i] = 32'h100 + 32'(4 * i); req_wdata[i] = 32'h1000 + 32'(i);
    end
    req_valid = '1;
    gb = n_grant; ib = n_issue; rb = n_rsp; wb = n_wr_hi;
    tick(); ARESETN = 1'b1;
    for (int k = 0; k < 5; k++) serve(2, 32'hC0DE0000 + 32'(k), 1'b1);
    req_valid = '0;
    repeat (3) tick();
    check("rr_grants", n_grant - gb, 5);
    for (int k = 0; k < 5; k++) check("rr_order", grant_idx[gb + k], exp_order[k]);
    check("rr_issues", n_issue - ib, 5);
    check("rr_wr_pulses", n_wr_hi - wb, 2);
    check("rr_rsps", n_rsp - rb, 5);

    // Single read from requester 1, rd_done at T+4.
    gb = n_grant; ib = n_issue; rb = n_rsp;
    req_write = '0; req_addr[1] = 32'h10; req_valid = 4'b0010;
    tick(); req_valid = '0;
    repeat (3) tick();
    rd_done = 1'b1; rd_data = 32'hDEADBEEF;
    tick(); rd_done = 1'b0;
    repeat (2) tick();
    check("rd1_grant", grant_idx[gb], 1);
    check("rd1_issue_lat", issue_cyc[ib] - grant_cyc[gb], 1);
    check("rd1_rsp_lat", rsp_cyc[rb] - grant_cyc[gb], 5);
    check("rd1_rsp_idx", rsp_idx[rb], 1);
    check("rd1_rdata", rsp_dat[rb], 32'hDEADBEEF);
    check("rd1_err", rsp_e[rb], 0);
    check("rd1_addr", Read_Address, 32'h10);

    // Write from requester 2 with a stray rd_done during WAIT.
    gb = n_grant; rb = n_rsp; wb = n_wr_hi;
    req_write = 4'b0100; req_addr[2] = 32'h4; req_wdata[2] = 32'hA5A5A5A5; req_valid = 4'b0100;
    tick(); req_valid = '0;
    tick(); rd_done = 1'b1; rd_data = 32'hBAD0BAD0;
    tick(); rd_done = 1'b0;
    tick();
    tick(); wr_done = 1'b1;
    tick(); wr_done = 1'b0;
    repeat (2) tick();
    check("wr_pulse_width", n_wr_hi - wb, 1);
    check("wr_rsp_count", n_rsp - rb, 1);
    check("wr_rsp_lat", rsp_cyc[rb] - grant_cyc[gb], 6);
    check("wr_rsp_idx", rsp_idx[rb], 2);
    check("wr_err", rsp_e[rb], 0);
    check("wr_addr", Write_Address, 32'h4);
    check("wr_data", Write_Data, 32'hA5A5A5A5);

    // Reset during WAIT, then a late rd_done; afterwards 0 must beat 3.
    rb = n_rsp;
    req_write = '0; req_addr[1] = 32'h20; req_valid = 4'b0010;
    tick(); req_valid = '0;
    repeat (2) tick();
    ARESETN = 1'b0;
    repeat (2) tick();
    ARESETN = 1'b1;
    tick(); rd_done = 1'b1; rd_data = 32'h11111111;
    tick(); rd_done = 1'b0;
    repeat (4) tick();
    check("rst_no_rsp", n_rsp - rb, 0);
    check("rst_read_addr_held", Read_Address, 0);
    gb = n_grant;
    req_addr[0] = 32'h30; req_addr[3] = 32'h34; req_valid = 4'b1001;
    serve(2, 32'h0A0A0A0A, 1'b0);
    serve(2, 32'h3B3B3B3B, 1'b0);
    repeat (2) tick();
    check("rst_first_grant", grant_idx[gb], 0);
    check("rst_second_grant", grant_idx[gb + 1], 3);

`ifdef AXI4_ARB_TIMEOUT_EN
    // No done at all: timeout error completion.
    ib = n_issue; rb = n_rsp;
    req_addr[3] = 32'h40; req_valid = 4'b1000;
    tick(); req_valid = '0;
    for (int i = 0; i < 30 && n_rsp == rb; i++) tick();
    check("to_rsp_seen", n_rsp - rb, 1);
    check("to_lat", rsp_cyc[rb] - issue_cyc[ib], 9);
    check("to_idx", rsp_idx[rb], 3);
    check("to_err", rsp_e[rb], 1);
    check("to_rdata", rsp_dat[rb], 0);
    tick();
    rb = n_rsp;
    req_addr[0] = 32'h44; req_valid = 4'b0001;
    serve(2, 32'h55, 1'b0);
    repeat (2) tick();
    check("after_to_err", rsp_e[rb], 0);
    check("after_to_rdata", rsp_dat[rb], 32'h55);

    // rd_done lands on the timeout cycle: completion wins.
    ib = n_issue; rb = n_rsp;
    req_addr[2] = 32'h48; req_valid = 4'b0100;
    tick(); req_valid = '0;
    repeat (8) tick();
    rd_done = 1'b1; rd_data = 32'h12345678;
    tick(); rd_done = 1'b0;
    repeat (2) tick();
    check("tie_lat", rsp_cyc[rb] - issue_cyc[ib], 9);
    check("tie_err", rsp_e[rb], 0);
    check("tie_rdata", rsp_dat[rb], 32'h12345678);
`endif

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/axi4_lite_req_arbiter.md
# axi4_lite_req_arbiter

Round-robin arbiter and sequencer that shares the single `axi4_lite_master` command port (rd_en/wr_en, Read_Address/Write_Address, Write_Data) among NUM_REQ requesters.

- Grants one transaction at a time and issues it to the master as a one-cycle enable pulse.
- Waits for the master's read/write completion indication, then returns read data (or an error) to the granted requester.
- Sits between testbench/system requesters and the master instance attached to `bfm.master_if`.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 256, WAIT-state cycles before an error completion (only with timeout enabled)
- ACLK  in  1  clock, all logic on rising edge
- ARESETN  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  request pending per requester; held until req_ready
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ x Addr_Width  request address
- req_wdata  in  NUM_REQ x Data_Width  write data
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  Data_Width  read data, valid with rsp_valid
- rsp_err  out  1  timeout completion flag, valid with rsp_valid
- rd_en, wr_en  out  1  one-cycle issue pulses to the master
- Read_Address, Write_Address  out  Addr_Width  to the master
- Write_Data  out  Data_Width  to the master
- rd_done  in  1  read data handshake complete (RVALID && RREADY)
- wr_done  in  1  write response handshake complete (BVALID && BREADY)
- rd_data  in  Data_Width  RDATA, sampled with rd_done

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - When any req_valid is set, choose the winner g: first set bit searching from (ptr+1) mod NUM_REQ upward, with wrap-around.
  - Assert req_ready[g] combinationally that cycle.
  - Latch write/addr/wdata/g into command registers; set ptr <= g; go to ISSUE.
  - No req_valid: stay in IDLE.
- **ISSUE**
  - Drive wr_en=1 (write) or rd_en=1 (read) for exactly one cycle.
  - Drive Write_Address/Write_Data or Read_Address from the command registers.
  - Clear the timeout counter; go to WAIT.
- **WAIT**
  - For a write, only wr_done completes; for a read, only rd_done completes.
  - On completion: latch rd_data (reads) and go to RESP with err=0.
  - A non-matching done pulse is ignored.
  - Timeout enabled: when the counter reaches TIMEOUT_CYCLES-1 without completion, go to RESP with err=1 and rdata=0.
  - Completion and timeout in the same cycle: completion wins.
- **RESP**
  - Pulse rsp_valid[g] for one cycle with rsp_rdata/rsp_err, then return to IDLE.
- Done pulses arriving in IDLE, ISSUE or RESP are ignored.
- Addresses and data hold their last value between transactions. rd_en and wr_en are never high together.
- Fairness: a requester that keeps req_valid asserted is granted within NUM_REQ transactions.

## Timing
- Reset values:
  - state=IDLE; ptr=NUM_REQ-1, so requester 0 has first priority.
  - All enables, req_ready, rsp_valid and rsp_err = 0.
  - Addresses, data and rsp_rdata = 0.
  - Timeout counter = 0.
- Reset asserted mid-transaction: abort immediately to reset state, no rsp_valid; a done arriving after reset release is ignored.
- Accept in cycle T: rd_en/wr_en at T+1; done sampled from T+2; rsp_valid one cycle after the done.
  - Minimum accept-to-response latency: 3 cycles.
  - Next accept no earlier than the cycle after rsp_valid.
- Outputs to the master and rsp_* are registered; only req_ready is combinational.

## Configuration
- Macro AXI4_ARB_TIMEOUT_EN.
- Defined: WAIT timeout counter (width $clog2(TIMEOUT_CYCLES)) present; rsp_err reports timeouts.
- Undefined: no counter; WAIT holds until the matching done; rsp_err tied to 0.

## Structure
- Package axi4_lite_Defs:
  - Add typedef enum logic [1:0] arb_state_e {IDLE, ISSUE, WAIT, RESP}.
  - Reuse the existing Addr_Width/Data_Width.
- Sub-module rr_arbiter:
  - Inputs: req vector and ptr.
  - Output: one-hot grant plus encoded index.
  - Purely combinational; ptr register stays in the parent.

## Test plan
- Single read from req 1, addr 0x10, rd_done at T+4 with rd_data 0xDEADBEEF -> rd_en at T+1, Read_Address 0x10, rsp_valid[1] at T+5, rsp_rdata 0xDEADBEEF, rsp_err 0.
- All 4 requesters hold req_valid from reset, done 2 cycles after each issue -> grant order 0,1,2,3,0; exactly one rd_en/wr_en per grant.
- Write from req 2 (addr 0x4, data 0xA5A5A5A5) with a stray rd_done during WAIT -> stray ignored; completes only on wr_done; wr_en pulse width 1.
- AXI4_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no done -> rsp_valid 9 cycles after issue, rsp_err 1, rsp_rdata 0; next request accepted normally.
- ARESETN low during WAIT, then later rd_done -> no rsp_valid; outputs at reset values; ptr reset so req 0 wins against req 3.
- Completion and timeout in the same cycle -> rsp_err 0 with captured rd_data.
